cr_kme_fifo_unpack: RTL and testbench
=====================================

# cr_kme_fifo_unpack

Downstream stage of the KME 263-bit entry FIFO. It pops one entry at a time over the FIFO's show-ahead valid/ack interface and unpacks the 256-bit payload into 1–4 beats of 64 bits with a valid/ready handshake. It also checks SOP/EOP framing and counts unpacked entries. It feeds the KME key-op datapath, which consumes 64-bit beats.

## Interface
- IN_W, 263, FIFO entry width; layout fixed as below, not overridable.
- BEAT_W, 64, output beat width.
- CNT_W, 16, width of the entry counter.

Ports:
- clk  in  1  clock; all state rises on clk.
- rst  in  1  reset, asynchronous and active-high; clears all state.
- fifo_out  in  263  FIFO head entry, valid while fifo_out_valid is high:
  - [255:0] payload
  - [257:256] nbeats_m1
  - [258] sop
  - [259] eop
  - [262:260] tag
- fifo_out_valid  in  1  FIFO not empty.
- fifo_out_ack  out  1  pop request; the FIFO pops when fifo_out_valid && fifo_out_ack.
- flush  in  1  synchronous drop of the held entry and framing state.
- out_valid  out  1  beat valid.
- out_ready  in  1  downstream accepts beat.
- out_data  out  64  beat data.
- out_tag  out  3  tag of the source entry.
- out_sop  out  1  first beat of an entry whose sop=1.
- out_eop  out  1  last beat of an entry whose eop=1.
- out_last  out  1  last beat of the current entry.
- framing_err  out  1  one-cycle pulse on a framing violation.
- entry_cnt  out  CNT_W  saturating count of fully emitted entries.

## Operation
- State machine: IDLE (no entry held) and BUSY (entry held in the internal register; beat index bidx in 0..3).
- Pop rule (combinational):
  - fifo_out_ack = fifo_out_valid && !flush && (state==IDLE || (out_valid && out_ready && out_last)).
  - An entry is never popped while a non-final beat is pending.
- Capture: on a pop, the register loads fifo_out and sets bidx=0. State is BUSY the next cycle.
- Emit:
  - In BUSY, out_valid=1 and out_data=payload[64*bidx +: 64].
  - out_last = (bidx==nbeats_m1).
  - out_sop = sop && bidx==0.
  - out_eop = eop && out_last.
- Advance on out_valid && out_ready:
  - If not last: bidx+1.
  - If last and a pop occurs the same cycle: reload, stay BUSY.
  - If last and no pop: go to IDLE.
- Hold: while out_valid && !out_ready, out_data, out_tag, out_sop, out_eop and out_last stay stable.
- Framing: in_pkt sets on the last beat of an entry with sop && !eop, and clears on the last beat of an entry with eop.
  - At capture, framing_err pulses for 1 cycle if (sop && in_pkt) or (!sop && !in_pkt).
  - The entry is still emitted unchanged.
- entry_cnt: increments on the accepted last beat of each entry and saturates at 2^CNT_W-1.
- flush:
  - Next cycle: state=IDLE, in_pkt=0, out_valid=0.
  - No pop in a cycle where flush=1.
  - entry_cnt is unaffected.
  - A beat accepted in the flush cycle still counts if it is last.

## Timing
- Reset values: state=IDLE, out_valid=0, out_data=0, out_tag=0, out_sop=0, out_eop=0, out_last=0, framing_err=0, entry_cnt=0, in_pkt=0. fifo_out_ack=0 during reset.
- Latency: an entry popped in cycle N presents beat 0 in cycle N+1.
- Throughput: with out_ready held high, one beat per cycle and no bubble between entries. A 4-beat entry takes 4 cycles; a 1-beat entry takes 1 cycle.
- framing_err is asserted in cycle N+1 for an entry popped in cycle N.
- Reset mid-entry: the held entry is discarded. An entry already popped by the FIFO is lost; that is accepted behaviour.
- fifo_out_valid falling while BUSY has no effect on the entry being emitted.
- nbeats_m1=0 with sop=eop=1: one beat with out_sop=out_eop=out_last=1.

## Test plan
- Single entry, payload = 256'h{4{64'hA5}} + incrementing words, nbeats_m1=3, sop=eop=1, tag=5, out_ready=1.
  - Ack in cycle 0; beats w0..w3 in cycles 1–4.
  - out_sop only in cycle 1; out_eop and out_last only in cycle 4; out_tag=5 throughout.
  - entry_cnt=1.
- Back-to-back: three entries queued (nbeats_m1 = 3, 0, 1), out_ready=1.
  - 7 consecutive valid beats with no gaps.
  - Acks in cycles 0, 4, 5.
  - entry_cnt=3.
- Backpressure: out_ready toggles 1,0,0,1 during a 4-beat entry.
  - out_data is held across the stalled cycles.
  - No ack until the last beat is accepted.
  - Total 6 cycles from first beat.
- Framing errors:
  - Entry sop=1 eop=0, then sop=1 -> framing_err pulses once.
  - Entry sop=0 while idle -> framing_err pulses once.
  - Both entries are still emitted.
- flush on beat 1 of a 4-beat entry -> out_valid=0 next cycle, no ack in the flush cycle, entry_cnt unchanged.
- Reset: assert rst asynchronously mid-entry -> all outputs return to reset values immediately. After release, the next FIFO entry is unpacked from beat 0. Also preload entry_cnt near saturation and check it saturates at 16'hFFFF.

Source files
------------

// File: rtl/cr_kme_fifo_unpack.sv
// cr_kme_fifo_unpack
//   Sits behind the KME 263-bit entry FIFO. It pops one entry at a time over
//   the FIFO's show-ahead valid/ack interface and emits the 256-bit payload as
//   1..4 beats of 64 bits on a valid/ready interface. It also tracks SOP/EOP
//   framing and counts the entries it has fully emitted.
//
//   Ports
//     clk, rst           clock; asynchronous active-high reset
//     fifo_out[262:0]    FIFO head: {tag[2:0], eop, sop, nbeats_m1[1:0], payload[255:0]}
//     fifo_out_valid     FIFO not empty
//     fifo_out_ack       pop strobe (FIFO pops on valid && ack)
//     flush              synchronous drop of the held entry and framing state
//     out_valid/ready    beat handshake
//     out_data/tag       beat data, tag of the source entry
//     out_sop/eop/last   first beat of a sop entry / last beat of an eop entry / last beat
//     framing_err        one-cycle pulse, the cycle after a badly framed entry is popped
//     entry_cnt          saturating count of fully emitted entries
module cr_kme_fifo_unpack #(
  parameter int BEAT_W = 64,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [262:0]      fifo_out,
  input  logic              fifo_out_valid,
  output logic              fifo_out_ack,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [BEAT_W-1:0] out_data,
  output logic [2:0]        out_tag,
  output logic              out_sop,
  output logic              out_eop,
  output logic              out_last,
  output logic              framing_err,
  output logic [CNT_W-1:0]  entry_cnt
);

  typedef enum logic {ST_IDLE, ST_BUSY} state_t;

  state_t           r_state, w_state_nxt;
  logic [262:0]     r_entry;
  logic [1:0]       r_bidx, w_bidx_nxt;
  logic             r_in_pkt, w_in_pkt_nxt;
  logic             r_ferr, w_ferr_nxt;
  logic [CNT_W-1:0] r_cnt;

  logic             w_busy, w_last, w_acc, w_acc_last, w_pop;
  logic             w_sop, w_eop;
  logic [1:0]       w_nb;

  assign w_busy     = (r_state == ST_BUSY);
  assign w_nb       = r_entry[257:256];
  assign w_sop      = r_entry[258];
  assign w_eop      = r_entry[259];
  assign w_last     = w_busy && (r_bidx == w_nb);
  assign w_acc      = w_busy && out_ready;
  assign w_acc_last = w_acc && w_last;
  // Reload on the accepted final beat keeps entries back-to-back with no bubble.
  assign w_pop      = !rst && fifo_out_valid && !flush && (!w_busy || w_acc_last);

  always_comb begin
    w_state_nxt  = r_state;
    w_bidx_nxt   = r_bidx;
    w_in_pkt_nxt = r_in_pkt;
    if (w_acc_last) begin
      if (w_eop)      w_in_pkt_nxt = 1'b0;
      else if (w_sop) w_in_pkt_nxt = 1'b1;
    end
    if (w_acc && !w_last) w_bidx_nxt = r_bidx + 2'd1;
    if (w_pop) begin
      w_state_nxt = ST_BUSY;
      w_bidx_nxt  = 2'd0;
    end else if (w_acc_last) begin
      w_state_nxt = ST_IDLE;
    end
    // Framing check sees the packet state after a same-cycle final beat of
    // the previous entry; a pop never coincides with flush.
    w_ferr_nxt = w_pop && (fifo_out[258] == w_in_pkt_nxt);
    if (flush) begin
      w_state_nxt  = ST_IDLE;
      w_in_pkt_nxt = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= ST_IDLE;
      r_entry  <= '0;
      r_bidx   <= '0;
      r_in_pkt <= 1'b0;
      r_ferr   <= 1'b0;
      r_cnt    <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_bidx   <= w_bidx_nxt;
      r_in_pkt <= w_in_pkt_nxt;
      r_ferr   <= w_ferr_nxt;
      if (w_pop) r_entry <= fifo_out;
      if (w_acc_last && (r_cnt != {CNT_W{1'b1}})) r_cnt <= r_cnt + 1'b1;
    end
  end

  // Outputs decode straight from the held entry, so they are stable under
  // backpressure and read zero whenever nothing is held.
  assign fifo_out_ack = w_pop;
  assign out_valid    = w_busy;
  assign out_data     = w_busy ? r_entry[int'(r_bidx)*BEAT_W +: BEAT_W] : '0;
  assign out_tag      = w_busy ? r_entry[262:260] : 3'd0;
  assign out_sop      = w_busy && w_sop && (r_bidx == 2'd0);
  assign out_eop      = w_last && w_eop;
  assign out_last     = w_last;
  assign framing_err  = r_ferr;
  assign entry_cnt    = r_cnt;

endmodule

// File: tb/tb_cr_kme_fifo_unpack.sv
module tb_cr_kme_fifo_unpack;
  logic         clk = 1'b0;
  logic         rst;
  logic [262:0] fifo_out;
  logic         fifo_out_valid, fifo_out_ack, flush;
  logic         out_valid, out_ready, out_sop, out_eop, out_last, framing_err;
  logic [63:0]  out_data;
  logic [2:0]   out_tag;
  logic [15:0]  entry_cnt;

  // small-counter instance for the saturation check
  logic [262:0] z_fifo_out;
  logic         z_valid, z_ack, z_ovalid, z_sop, z_eop, z_last, z_ferr;
  logic [63:0]  z_data;
  logic [2:0]   z_tag;
  logic [2:0]   z_cnt;

  always #5 clk = ~clk;

  cr_kme_fifo_unpack dut (
    .clk(clk), .rst(rst), .fifo_out(fifo_out), .fifo_out_valid(fifo_out_valid),
    .fifo_out_ack(fifo_out_ack), .flush(flush), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data), .out_tag(out_tag),
    .out_sop(out_sop), .out_eop(out_eop), .out_last(out_last),
    .framing_err(framing_err), .entry_cnt(entry_cnt));

  cr_kme_fifo_unpack #(.CNT_W(3)) zdut (
    .clk(clk), .rst(rst), .fifo_out(z_fifo_out), .fifo_out_valid(z_valid),
    .fifo_out_ack(z_ack), .flush(1'b0), .out_valid(z_ovalid),
    .out_ready(1'b1), .out_data(z_data), .out_tag(z_tag),
    .out_sop(z_sop), .out_eop(z_eop), .out_last(z_last),
    .framing_err(z_ferr), .entry_cnt(z_cnt));

  typedef struct packed {
    logic [63:0] d;
    logic [2:0]  tag;
    logic        sop, eop, last;
  } beat_t;

  typedef struct {
    logic [1:0]  nb;
    logic        sop, eop;
    logic [2:0]  tag;
    logic        ferr;
    logic [15:0] cnt;
  } vec_t;

  logic [262:0] fq[$];
  bit           fifo_en;
  int           n_pass, n_tot;

  logic         s_ack, s_vld, s_ferr;
  beat_t        s_beat;
  logic [15:0]  s_cnt;

  function automatic logic [262:0] mk(logic [1:0] nb, logic sop, logic eop,
                                      logic [2:0] tag, logic [255:0] pl);
    return {tag, eop, sop, nb, pl};
  endfunction

  function automatic logic [255:0] seqpl(logic [63:0] base);
    logic [255:0] pl;
    for (int w = 0; w < 4; w++) pl[64*w +: 64] = base + 64'(w);
    return pl;
  endfunction

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  // One clock: present FIFO head, sample at negedge, pop the model FIFO on ack.
  task automatic cyc();
    fifo_out_valid = fifo_en && (fq.size() > 0);
    fifo_out       = (fq.size() > 0) ? fq[0] : '0;
    @(negedge clk);
    s_ack  = fifo_out_ack;
    s_vld  = out_valid;
    s_ferr = framing_err;
    s_beat = {out_data, out_tag, out_sop, out_eop, out_last};
    s_cnt  = entry_cnt;
    @(posedge clk);
    #1;
    if (s_ack) void'(fq.pop_front());
  endtask

  vec_t         tbl[8];
  logic [8:0]   av, vv;
  logic [63:0]  dd[9];
  logic [8:0]   lv;
  logic [63:0]  got[$];
  logic [63:0]  expd[7];
  int           rp[7];
  beat_t        eb, prev_b;
  beat_t        beats[$];
  logic         ferrq[$];
  logic         pend, exp_f, pkt, prev_stall;
  int           cycles;

  initial begin
    n_pass = 0; n_tot = 0;
    fifo_en = 1; flush = 1'b0; out_ready = 1'b1;
    z_valid = 1'b0; z_fifo_out = mk(2'd0, 1'b1, 1'b1, 3'd2, '0);
    rst = 1'b1;
    fq.push_back(mk(2'd0, 1'b1, 1'b1, 3'd1, seqpl(64'h11)));
    fifo_out_valid = 1'b1; fifo_out = fq[0];
    #12;
    chk("rst_ctl", 128'({out_valid, out_sop, out_eop, out_last, framing_err, out_tag, fifo_out_ack}), 128'(0));
    chk("rst_data", 128'(out_data), 128'(0));
    chk("rst_cnt", 128'(entry_cnt), 128'(0));
    fq.delete(); fifo_out_valid = 1'b0;
    @(posedge clk); #1; rst = 1'b0;

    // ---- table: single entries, framing sequence, count ----
    tbl[0] = '{2'd3, 1'b1, 1'b1, 3'd5, 1'b0, 16'd1};
    tbl[1] = '{2'd0, 1'b1, 1'b0, 3'd1, 1'b0, 16'd2};
    tbl[2] = '{2'd1, 1'b1, 1'b1, 3'd2, 1'b1, 16'd3};
    tbl[3] = '{2'd2, 1'b0, 1'b0, 3'd3, 1'b1, 16'd4};
    tbl[4] = '{2'd0, 1'b0, 1'b1, 3'd4, 1'b1, 16'd5};
    tbl[5] = '{2'd1, 1'b1, 1'b0, 3'd6, 1'b0, 16'd6};
    tbl[6] = '{2'd0, 1'b0, 1'b0, 3'd7, 1'b0, 16'd7};
    tbl[7] = '{2'd3, 1'b0, 1'b1, 3'd0, 1'b0, 16'd8};
    for (int i = 0; i < 8; i++) begin
      fq.push_back(mk(tbl[i].nb, tbl[i].sop, tbl[i].eop, tbl[i].tag, seqpl(64'hA5 + 64'(i*256))));
      cyc();
      chk($sformatf("t%0d_ack", i), 128'(s_ack), 128'(1));
      for (int b = 0; b <= int'(tbl[i].nb); b++) begin
        cyc();
        chk($sformatf("t%0d_b%0d_data", i, b), 128'(s_beat.d), 128'(64'hA5 + 64'(i*256) + 64'(b)));
        chk($sformatf("t%0d_b%0d_flags", i, b),
            128'({s_vld, s_beat.tag, s_beat.sop, s_beat.eop, s_beat.last, s_ferr}),
            128'({1'b1, tbl[i].tag, tbl[i].sop && (b == 0), tbl[i].eop && (b == int'(tbl[i].nb)),
                  b == int'(tbl[i].nb), (b == 0) ? tbl[i].ferr : 1'b0}));
      end
      cyc();
      chk($sformatf("t%0d_idle", i), 128'({s_vld, s_ferr, s_cnt}), 128'({1'b0, 1'b0, tbl[i].cnt}));
    end

    // ---- back-to-back: nbeats_m1 = 3, 0, 1 ----
    fq.push_back(mk(2'd3, 1'b1, 1'b1, 3'd1, seqpl(64'h100)));
    fq.push_back(mk(2'd0, 1'b1, 1'b1, 3'd2, seqpl(64'h200)));
    fq.push_back(mk(2'd1, 1'b1, 1'b1, 3'd3, seqpl(64'h300)));
    got.delete();
    for (int c = 0; c < 9; c++) begin
      cyc(); av[c] = s_ack; vv[c] = s_vld;
      if (s_vld) got.push_back(s_beat.d);
    end
    chk("b2b_acks", 128'(av), 128'(9'b000110001));
    chk("b2b_valid", 128'(vv), 128'(9'b011111110));
    expd = '{64'h100, 64'h101, 64'h102, 64'h103, 64'h200, 64'h300, 64'h301};
    chk("b2b_nbeats", 128'(got.size()), 128'(7));
    for (int k = 0; k < 7 && k < got.size(); k++)
      chk($sformatf("b2b_d%0d", k), 128'(got[k]), 128'(expd[k]));
    chk("b2b_cnt", 128'(s_cnt), 128'(11));

    // ---- backpressure: ready 1,0,0,1 across a 4-beat entry ----
    fq.push_back(mk(2'd3, 1'b1, 1'b1, 3'd4, seqpl(64'hB0)));
    fq.push_back(mk(2'd0, 1'b1, 1'b1, 3'd4, seqpl(64'hC0)));
    rp = '{1, 1, 0, 0, 1, 1, 1};
    for (int c = 0; c < 7; c++) begin
      out_ready = (rp[c] != 0);
      cyc(); av[c] = s_ack; dd[c] = s_beat.d; lv[c] = s_beat.last;
    end
    out_ready = 1'b1;
    chk("bp_acks", 128'(av[6:0]), 128'(7'b1000001));
    chk("bp_hold2", 128'(dd[2]), 128'(64'hB1));
    chk("bp_hold3", 128'(dd[3]), 128'(64'hB1));
    chk("bp_acc", 128'({dd[4], dd[5], dd[6]}), 128'({64'hB1, 64'hB2}) << 64 | 128'(64'hB3));
    chk("bp_last", 128'(lv[6:1]), 128'(6'b100000));
    cyc();
    chk("bp_next", 128'({s_vld, s_beat.d, s_beat.last}), 128'({1'b1, 64'hC0, 1'b1}));
    cyc();
    chk("bp_cnt", 128'({s_vld, s_cnt}), 128'({1'b0, 16'd13}));

    // ---- flush on beat 1 of a 4-beat entry ----
    fq.push_back(mk(2'd3, 1'b1, 1'b1, 3'd6, seqpl(64'hD0)));
    fq.push_back(mk(2'd0, 1'b1, 1'b1, 3'd7, seqpl(64'hE0)));
    cyc(); chk("fl_ack0", 128'(s_ack), 128'(1));
    cyc(); chk("fl_b0", 128'(s_beat.d), 128'(64'hD0));
    flush = 1'b1;
    cyc(); chk("fl_cyc", 128'({s_ack, s_vld, s_beat.d}), 128'({1'b0, 1'b1, 64'hD1}));
    cyc(); chk("fl_idle", 128'({s_ack, s_vld, s_cnt}), 128'({1'b0, 1'b0, 16'd13}));
    flush = 1'b0;
    cyc(); chk("fl_pop", 128'({s_ack, s_vld}), 128'({1'b1, 1'b0}));
    cyc(); chk("fl_next", 128'({s_vld, s_beat.d, s_beat.sop, s_ferr}), 128'({1'b1, 64'hE0, 1'b1, 1'b0}));
    cyc(); chk("fl_cnt", 128'({s_vld, s_cnt}), 128'({1'b0, 16'd14}));

    // ---- randomized against a beat-stream/framing model ----
    pkt = 1'b0;
    for (int i = 0; i < 30; i++) begin
      logic [1:0]   nb;
      logic         sp, ep;
      logic [2:0]   tg;
      logic [255:0] pl;
      nb = 2'($urandom_range(0, 3)); sp = 1'($urandom_range(0, 1));
      ep = 1'($urandom_range(0, 1)); tg = 3'($urandom_range(0, 7));
      for (int w = 0; w < 8; w++) pl[32*w +: 32] = $urandom;
      fq.push_back(mk(nb, sp, ep, tg, pl));
      ferrq.push_back(sp == pkt);
      if (ep) pkt = 1'b0;
      else if (sp) pkt = 1'b1;
      for (int b = 0; b <= int'(nb); b++)
        beats.push_back({pl[64*b +: 64], tg, sp && (b == 0), ep && (b == int'(nb)), b == int'(nb)});
    end
    pend = 1'b0; prev_stall = 1'b0; cycles = 0; prev_b = '0;
    while (beats.size() > 0 && cycles < 3000) begin
      out_ready = ($urandom_range(0, 3) != 0);
      fifo_en   = ($urandom_range(0, 4) != 0);
      cyc(); cycles++;
      exp_f = pend; pend = 1'b0;
      if (s_ack) pend = (ferrq.size() > 0) ? ferrq.pop_front() : 1'b0;
      chk("rnd_ferr", 128'(s_ferr), 128'(exp_f));
      if (s_ack && s_vld) chk("rnd_ack_rule", 128'(s_beat.last && out_ready), 128'(1));
      if (prev_stall) chk("rnd_hold", 128'({s_vld, s_beat}), 128'({1'b1, prev_b}));
      if (s_vld && out_ready) begin
        eb = beats.pop_front();
        chk("rnd_beat", 128'(s_beat), 128'(eb));
      end
      prev_stall = s_vld && !out_ready; prev_b = s_beat;
    end
    chk("rnd_drained", 128'(beats.size()), 128'(0));
    out_ready = 1'b1; fifo_en = 1;
    cyc();
    chk("rnd_cnt", 128'({s_vld, s_ferr, s_cnt}), 128'({1'b0, pend, 16'd44}));
    fq.delete();

    // ---- asynchronous reset mid-entry ----
    fq.push_back(mk(2'd3, 1'b1, 1'b1, 3'd5, seqpl(64'h0F00)));
    fq.push_back(mk(2'd1, 1'b1, 1'b1, 3'd3, seqpl(64'h1000)));
    cyc(); cyc(); cyc();
    chk("ar_pre", 128'({s_vld, s_beat.d}), 128'({1'b1, 64'h0F01}));
    #2 rst = 1'b1;
    #1;
    chk("ar_ctl", 128'({out_valid, out_sop, out_eop, out_last, framing_err, out_tag, fifo_out_ack}), 128'(0));
    chk("ar_data", 128'({out_data, entry_cnt}), 128'(0));
    @(posedge clk); #1; rst = 1'b0;
    cyc(); chk("ar_pop", 128'({s_ack, s_vld}), 128'({1'b1, 1'b0}));
    cyc(); chk("ar_b0", 128'({s_beat.d, s_beat.tag, s_beat.sop, s_beat.last}), 128'({64'h1000, 3'd3, 1'b1, 1'b0}));
    cyc(); chk("ar_b1", 128'({s_beat.d, s_beat.eop, s_beat.last}), 128'({64'h1001, 1'b1, 1'b1}));
    cyc(); chk("ar_cnt", 128'({s_vld, s_cnt}), 128'({1'b0, 16'd1}));

    // ---- counter saturation (3-bit counter instance) ----
    z_valid = 1'b1;
    repeat (4) @(posedge clk);
    #1 chk("sat_mid", 128'(z_cnt), 128'(3));
    repeat (10) @(posedge clk);
    #1 chk("sat_max", 128'(z_cnt), 128'(7));
    z_valid = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
